// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Counter width for n states, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Request/result handshake bundle between the ALU controller (master) and addsub_serial (slave).
interface addsub_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i_valid;
  logic             o_ready;
  logic             i_sub;
  logic             i_cin;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_S;
  logic             o_C;
  logic             o_V;
  logic             o_Z;
  logic             o_N;

  modport master (
    output i_valid, i_sub, i_cin, i_A, i_B, i_ready,
    input  o_ready, o_valid, o_S, o_C, o_V, o_Z, o_N
  );

  modport slave (
    input  i_valid, i_sub, i_cin, i_A, i_B, i_ready,
    output o_ready, o_valid, o_S, o_C, o_V, o_Z, o_N
  );
endinterface

// File: rtl/addsub_fa.sv
// One-bit full adder cell.
module addsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit for overflow.
module addsub_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    addsub_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract, CHUNK bits per clock through one shared slice, with C/V/Z/N flags.
// Optional feature: define ADDSUB_SAT_EN to clamp overflowing results to signed max/min.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  addsub_serial_if.slave bus
);
  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = clog2_min1(NCH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q, v_q, z_q, n_q;
  logic             ready_q, valid_q;

  logic [CHUNK-1:0]       slice_s;
  logic                   slice_cout, slice_cmsb;
  logic [WIDTH+CHUNK-1:0] s_cat;
  logic [WIDTH-1:0]       s_shift;
  logic [WIDTH-1:0]       s_fin;
  logic                   v_fin;
  logic                   last;

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a        (a_q[CHUNK-1:0]),
    .b        (b_q[CHUNK-1:0]),
    .cin      (carry_q),
    .s        (slice_s),
    .cout     (slice_cout),
    .c_msb_in (slice_cmsb)
  );

  // Operands shift down one chunk per cycle; each new sum chunk enters the result from the top,
  // so after NCH cycles chunk k sits at bits k*CHUNK +: CHUNK.
  assign s_cat   = {slice_s, s_q};
  assign s_shift = s_cat[WIDTH+CHUNK-1:CHUNK];
  assign v_fin   = slice_cmsb ^ slice_cout;
  assign last    = (cnt == CW'(NCH - 1));

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = ~SMAX;

  // On overflow the wrapped sign is the inverse of the true sign.
  always_comb begin
    s_fin = s_shift;
    if (v_fin) s_fin = s_shift[WIDTH-1] ? SMAX : SMIN;
  end
`else
  assign s_fin = s_shift;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            state   <= CALC;
            ready_q <= 1'b0;
            cnt     <= '0;
            a_q     <= bus.i_A;
            b_q     <= (bus.i_sub == OP_ADD) ? bus.i_B : ~bus.i_B;
            carry_q <= (bus.i_sub == OP_SUB) ^ bus.i_cin;
          end
        end
        CALC: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= slice_cout;
          s_q     <= s_shift;
          cnt     <= cnt + CW'(1);
          if (last) begin
            state   <= DONE;
            cnt     <= '0;
            s_q     <= s_fin;
            c_q     <= slice_cout;
            v_q     <= v_fin;
            z_q     <= (s_fin == '0);
            n_q     <= s_fin[WIDTH-1];
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_S     = s_q;
  assign bus.o_C     = c_q;
  assign bus.o_V     = v_q;
  assign bus.o_Z     = z_q;
  assign bus.o_N     = n_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial (WIDTH=16, CHUNK=4); expected results are hand-computed constants.
module tb_addsub_serial;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned NCH   = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  res_t sb[$];
  logic prev_valid;

  addsub_serial_if #(.WIDTH(WIDTH)) bus ();

  addsub_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each new result against the oldest scoreboard entry.
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    if (bus.o_valid === 1'b1 && !prev_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("S", 32'(bus.o_S), 32'(e.s));
        check("C", 32'(bus.o_C), 32'(e.c));
        check("V", 32'(bus.o_V), 32'(e.v));
        check("Z", 32'(bus.o_Z), 32'(e.z));
        check("N", 32'(bus.o_N), 32'(e.n));
      end
    end
    prev_valid = (bus.o_valid === 1'b1);
  end

  task automatic do_op(input logic sub, input logic cin, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input res_t e, input bit bp);
    int lat;
    int w;
    bus.i_ready = !bp;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_sub   = sub;
    bus.i_cin   = cin;
    bus.i_A     = a;
    bus.i_B     = b;
    w = 0;
    while (bus.o_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.i_valid = 1'b0;
    bus.i_sub   = ~sub;
    bus.i_cin   = ~cin;
    bus.i_A     = 16'hDEAD;
    bus.i_B     = 16'hBEEF;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'(NCH));
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("bp_valid", 32'(bus.o_valid), 32'd1);
        check("bp_ready", 32'(bus.o_ready), 32'd0);
        check("bp_S", 32'(bus.o_S), 32'(e.s));
        check("bp_flags", 32'({bus.o_C, bus.o_V, bus.o_Z, bus.o_N}), 32'({e.c, e.v, e.z, e.n}));
        bus.i_valid = k[0];
        bus.i_A     = 16'(k * 16'h1111);
        bus.i_B     = 16'(16'h0F0F ^ 16'(k));
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_ready", 32'(bus.o_ready), 32'd1);
      check("bp_release_valid", 32'(bus.o_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("bp_nothing_accepted", 32'(bus.o_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
      check("back_to_idle", 32'(bus.o_ready), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    res_t e;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sub   = 1'b0;
    bus.i_cin   = 1'b0;
    bus.i_A     = '0;
    bus.i_B     = '0;
    bus.i_ready = 1'b1;
    #12;
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_outs", 32'({bus.o_S, bus.o_C, bus.o_V, bus.o_Z, bus.o_N}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    e = '{s: 16'h2345, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
    do_op(1'b0, 1'b0, 16'h1234, 16'h1111, e, 1'b0);
    e = '{s: 16'h0000, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0};
    do_op(1'b0, 1'b0, 16'hFFFF, 16'h0001, e, 1'b0);
    e = '{s: 16'hFFFF, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1};
    do_op(1'b1, 1'b0, 16'h0000, 16'h0001, e, 1'b0);
    e = '{s: 16'h0002, c: 1'b1, v: 1'b0, z: 1'b0, n: 1'b0};
    do_op(1'b1, 1'b1, 16'h0005, 16'h0002, e, 1'b0);
`ifdef ADDSUB_SAT_EN
    e = '{s: 16'h7FFF, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b0};
`else
    e = '{s: 16'h8000, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1};
`endif
    do_op(1'b0, 1'b0, 16'h7FFF, 16'h0001, e, 1'b0);
`ifdef ADDSUB_SAT_EN
    e = '{s: 16'h8000, c: 1'b1, v: 1'b1, z: 1'b0, n: 1'b1};
`else
    e = '{s: 16'h7FFF, c: 1'b1, v: 1'b1, z: 1'b0, n: 1'b0};
`endif
    do_op(1'b1, 1'b0, 16'h8000, 16'h0001, e, 1'b0);
    e = '{s: 16'h0000, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0};
    do_op(1'b0, 1'b1, 16'hA5A5, 16'h5A5A, e, 1'b0);
    e = '{s: 16'h1000, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
    do_op(1'b0, 1'b0, 16'h0F0F, 16'h00F1, e, 1'b1);

    // Abort: reset lands in the second CALC cycle; nothing is pushed, so any o_valid is flagged.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_sub   = 1'b0;
    bus.i_cin   = 1'b0;
    bus.i_A     = 16'h1234;
    bus.i_B     = 16'h1111;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(bus.o_ready), 32'd1);
    check("abort_valid", 32'(bus.o_valid), 32'd0);
    check("abort_outs", 32'({bus.o_S, bus.o_C, bus.o_V, bus.o_Z, bus.o_N}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_valid", 32'(bus.o_valid), 32'd0);

    e = '{s: 16'h2345, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0};
    do_op(1'b0, 1'b0, 16'h1234, 16'h1111, e, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
